// File: rtl/llc_input_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// llc_input_scheduler_pkg - shared types for the LLC input scheduler slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package llc_input_scheduler_pkg;

  localparam int DEF_LLC_SET_BITS = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef logic [DEF_LLC_SET_BITS-1:0] llc_set_t;

  typedef enum logic [2:0] {
    SRC_RST     = 3'd0,
    SRC_FLUSH   = 3'd1,
    SRC_RSP     = 3'd2,
    SRC_DMA_RD  = 3'd3,
    SRC_DMA_WR  = 3'd4,
    SRC_REQ     = 3'd5,
    SRC_DMA_REQ = 3'd6,
    SRC_NONE    = 3'd7
  } src_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/llc_input_scheduler_prio_enc.sv
// ---------------------------------------------------------------------------
// llc_src_prio_enc - eligibility and fixed-priority selection of LLC input source
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module llc_src_prio_enc
  import llc_input_scheduler_pkg::*;
(
  input  logic     rst_stall,
  input  logic     flush_stall,
  input  logic     req_stall,
  input  logic     starved,
  input  logic     rsp_valid,
  input  logic     req_valid,
  input  logic     dma_req_valid,
  input  logic     dma_read_pend,
  input  logic     dma_write_pend,
  output src_sel_t sel,
  output logic     req_eligible
);

  logic walk;
  logic rsp_ok;
  logic rd_ok;
  logic wr_ok;
  logic dma_req_ok;

  always_comb begin
    walk         = rst_stall | flush_stall;
    rsp_ok       = rsp_valid & ~walk;
    rd_ok        = dma_read_pend & ~walk;
    wr_ok        = dma_write_pend & ~walk;
    req_eligible = req_valid & ~req_stall & ~walk;
    dma_req_ok   = dma_req_valid & ~req_stall & ~walk;
    sel          = SRC_NONE;

    if (rst_stall) begin
      sel = SRC_RST;
    end else if (flush_stall) begin
      sel = SRC_FLUSH;
    end else if (starved && req_eligible) begin
      // A starved req jumps ahead of rsp only; DMA resumes still win.
      if (rd_ok)      sel = SRC_DMA_RD;
      else if (wr_ok) sel = SRC_DMA_WR;
      else            sel = SRC_REQ;
    end else if (rsp_ok) begin
      sel = SRC_RSP;
    end else if (rd_ok) begin
      sel = SRC_DMA_RD;
    end else if (wr_ok) begin
      sel = SRC_DMA_WR;
    end else if (req_eligible) begin
      sel = SRC_REQ;
    end else if (dma_req_ok) begin
      sel = SRC_DMA_REQ;
    end
  end

endmodule

`default_nettype wire

// File: rtl/llc_input_scheduler.sv
// ---------------------------------------------------------------------------
// llc_input_scheduler - picks the next LLC input source and strobes the set-read stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module llc_input_scheduler
  import llc_input_scheduler_pkg::*;
#(
  parameter int LLC_SET_BITS = DEF_LLC_SET_BITS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rsp_in_valid,
  input  logic                    req_in_valid,
  input  logic                    dma_req_in_valid,
  input  logic                    rst_start,
  input  logic                    flush_start,
  input  logic                    dma_read_pend,
  input  logic                    dma_write_pend,
  input  logic                    req_stall_set,
  input  logic                    clr_req_stall,
  input  logic                    proc_done,
  output logic                    rsp_in_ready,
  output logic                    req_in_ready,
  output logic                    dma_req_in_ready,
  output logic                    is_rsp_to_get,
  output logic                    is_req_to_get,
  output logic                    is_dma_req_to_get,
  output logic                    is_dma_read_to_resume,
  output logic                    is_dma_write_to_resume,
  output logic                    is_flush_to_resume,
  output logic                    is_rst_to_resume,
  output logic                    rd_set_en,
  output logic [LLC_SET_BITS-1:0] rst_flush_stalled_set,
  output logic                    rst_stall,
  output logic                    flush_stall,
  output logic                    req_stall,
  output logic                    busy
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  sched_state_t        state;
  sched_state_t        state_nxt;
  src_sel_t            grant;
  src_sel_t            grant_nxt;
  src_sel_t            sel;
  logic                req_eligible;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  logic                walk_issue;

  assign starved    = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign walk_issue = (state == ISSUE) && ((grant == SRC_RST) || (grant == SRC_FLUSH));

  llc_src_prio_enc u_prio_enc (
    .rst_stall      (rst_stall),
    .flush_stall    (flush_stall),
    .req_stall      (req_stall),
    .starved        (starved),
    .rsp_valid      (rsp_in_valid),
    .req_valid      (req_in_valid),
    .dma_req_valid  (dma_req_in_valid),
    .dma_read_pend  (dma_read_pend),
    .dma_write_pend (dma_write_pend),
    .sel            (sel),
    .req_eligible   (req_eligible)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= SRC_NONE;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt              = state;
    grant_nxt              = grant;
    busy                   = 1'b0;
    is_rst_to_resume       = 1'b0;
    is_flush_to_resume     = 1'b0;
    is_rsp_to_get          = 1'b0;
    is_dma_read_to_resume  = 1'b0;
    is_dma_write_to_resume = 1'b0;
    is_req_to_get          = 1'b0;
    is_dma_req_to_get      = 1'b0;
    rsp_in_ready           = 1'b0;
    req_in_ready           = 1'b0;
    dma_req_in_ready       = 1'b0;

    case (state)
      IDLE: begin
        if (sel != SRC_NONE) begin
          grant_nxt = sel;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        state_nxt = BUSY;
        case (grant)
          SRC_RST:     is_rst_to_resume       = 1'b1;
          SRC_FLUSH:   is_flush_to_resume     = 1'b1;
          SRC_RSP:     begin is_rsp_to_get     = 1'b1; rsp_in_ready     = 1'b1; end
          SRC_DMA_RD:  is_dma_read_to_resume  = 1'b1;
          SRC_DMA_WR:  is_dma_write_to_resume = 1'b1;
          SRC_REQ:     begin is_req_to_get     = 1'b1; req_in_ready     = 1'b1; end
          SRC_DMA_REQ: begin is_dma_req_to_get = 1'b1; dma_req_in_ready = 1'b1; end
          default:     ;
        endcase
      end
      BUSY: begin
        busy = 1'b1;
        if (proc_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    rd_set_en = is_rst_to_resume | is_flush_to_resume | is_rsp_to_get |
                is_dma_read_to_resume | is_dma_write_to_resume |
                is_req_to_get | is_dma_req_to_get;
  end

  // Walk ends on the issue of the all-ones set; starts during a walk are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_flush_stalled_set <= '0;
      rst_stall             <= 1'b0;
      flush_stall           <= 1'b0;
    end else if (walk_issue) begin
      rst_flush_stalled_set <= rst_flush_stalled_set + 1'b1;
      if (&rst_flush_stalled_set) begin
        rst_stall   <= 1'b0;
        flush_stall <= 1'b0;
      end
    end else if (!(rst_stall || flush_stall)) begin
      if (rst_start)   rst_stall   <= 1'b1;
      if (flush_start) flush_stall <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_stall <= 1'b0;
    end else if (clr_req_stall) begin
      req_stall <= 1'b0;
    end else if (req_stall_set) begin
      req_stall <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req_eligible) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (sel == SRC_REQ)  starve_cnt <= '0;
      else if (!starved)   starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_llc_input_scheduler.sv
// ---------------------------------------------------------------------------
// tb_llc_input_scheduler - directed scenarios plus random traffic vs. a cycle reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_llc_input_scheduler;

  localparam int SET_BITS = 4;
  localparam int NSETS    = 16;
  localparam int LIMIT    = 8;

  logic clk = 1'b0;
  logic rst;
  logic rsp_in_valid, req_in_valid, dma_req_in_valid, rst_start, flush_start;
  logic dma_read_pend, dma_write_pend, req_stall_set, clr_req_stall, proc_done;
  logic rsp_in_ready, req_in_ready, dma_req_in_ready;
  logic is_rsp_to_get, is_req_to_get, is_dma_req_to_get, is_dma_read_to_resume;
  logic is_dma_write_to_resume, is_flush_to_resume, is_rst_to_resume;
  logic rd_set_en, rst_stall, flush_stall, req_stall, busy;
  logic [SET_BITS-1:0] rst_flush_stalled_set;

  llc_input_scheduler #(.LLC_SET_BITS(SET_BITS), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .rsp_in_valid(rsp_in_valid), .req_in_valid(req_in_valid), .dma_req_in_valid(dma_req_in_valid),
    .rst_start(rst_start), .flush_start(flush_start),
    .dma_read_pend(dma_read_pend), .dma_write_pend(dma_write_pend),
    .req_stall_set(req_stall_set), .clr_req_stall(clr_req_stall), .proc_done(proc_done),
    .rsp_in_ready(rsp_in_ready), .req_in_ready(req_in_ready), .dma_req_in_ready(dma_req_in_ready),
    .is_rsp_to_get(is_rsp_to_get), .is_req_to_get(is_req_to_get), .is_dma_req_to_get(is_dma_req_to_get),
    .is_dma_read_to_resume(is_dma_read_to_resume), .is_dma_write_to_resume(is_dma_write_to_resume),
    .is_flush_to_resume(is_flush_to_resume), .is_rst_to_resume(is_rst_to_resume),
    .rd_set_en(rd_set_en), .rst_flush_stalled_set(rst_flush_stalled_set),
    .rst_stall(rst_stall), .flush_stall(flush_stall), .req_stall(req_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = grant cycle, 2 = transaction in flight.
  // Sources indexed 0..6 = rst, flush, rsp, dma_rd, dma_wr, req, dma_req.
  int m_phase, m_win, m_walk, m_starve;
  bit m_rst_st, m_fl_st, m_req_st;

  function automatic int pick();
    int order[7];
    bit elig[7];
    bit walk;
    walk    = m_rst_st || m_fl_st;
    elig[0] = m_rst_st;
    elig[1] = m_fl_st && !m_rst_st;
    elig[2] = rsp_in_valid && !walk;
    elig[3] = dma_read_pend && !walk;
    elig[4] = dma_write_pend && !walk;
    elig[5] = req_in_valid && !walk && !m_req_st;
    elig[6] = dma_req_in_valid && !walk && !m_req_st;
    if (m_starve >= LIMIT) order = '{0, 1, 3, 4, 5, 2, 6};
    else                   order = '{0, 1, 2, 3, 4, 5, 6};
    for (int i = 0; i < 7; i++) if (elig[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_win = 0; m_walk = 0; m_starve = 0;
    m_rst_st = 0; m_fl_st = 0; m_req_st = 0;
  endtask

  task automatic model_step();
    bit walk, req_elig, n_rst, n_fl;
    int w, np;
    walk     = m_rst_st || m_fl_st;
    req_elig = req_in_valid && !m_req_st && !walk;
    n_rst = m_rst_st; n_fl = m_fl_st;
    w  = -1;
    np = m_phase;
    if (m_phase == 0) begin
      w = pick();
      if (w >= 0) begin m_win = w; np = 1; end
    end else if (m_phase == 1) begin
      if (m_win <= 1) begin
        if (m_walk == NSETS - 1) begin n_rst = 0; n_fl = 0; end
        m_walk = (m_walk + 1) % NSETS;
      end
      np = 2;
    end else if (proc_done) begin
      np = 0;
    end
    if (!walk) begin
      if (rst_start)   n_rst = 1;
      if (flush_start) n_fl  = 1;
    end
    if (!req_elig)          m_starve = 0;
    else if (m_phase == 0)  m_starve = (w == 5) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
    if (clr_req_stall)      m_req_st = 0;
    else if (req_stall_set) m_req_st = 1;
    m_rst_st = n_rst; m_fl_st = n_fl; m_phase = np;
  endtask

  task automatic check_outputs();
    logic [6:0] exp_g, obs_g;
    exp_g = (m_phase == 1) ? 7'(32'd1 << m_win) : 7'd0;
    obs_g = {is_dma_req_to_get, is_req_to_get, is_dma_write_to_resume, is_dma_read_to_resume,
             is_rsp_to_get, is_flush_to_resume, is_rst_to_resume};
    check_eq("grant", 32'(obs_g), 32'(exp_g));
    check_eq("ready", {29'd0, dma_req_in_ready, req_in_ready, rsp_in_ready},
             {29'd0, exp_g[6], exp_g[5], exp_g[2]});
    check_eq("rd_set_en", 32'(rd_set_en), 32'(m_phase == 1));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    check_eq("stalls", {29'd0, rst_stall, flush_stall, req_stall}, {29'd0, m_rst_st, m_fl_st, m_req_st});
    check_eq("walk_set", 32'(rst_flush_stalled_set), 32'(m_walk));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_inputs();
    rsp_in_valid = 0; req_in_valid = 0; dma_req_in_valid = 0; rst_start = 0; flush_start = 0;
    dma_read_pend = 0; dma_write_pend = 0; req_stall_set = 0; clr_req_stall = 0; proc_done = 0;
  endtask

  task automatic settle();
    clear_inputs();
    proc_done = 1;
    repeat (3) tick();
    proc_done = 0;
  endtask

  int k, n, nf, req_seen;
  int intervals[$];

  initial begin
    clear_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 0;

    // 1: rsp beats req, then req follows
    rsp_in_valid = 1; req_in_valid = 1;
    tick();
    check_eq("t1_rsp_get", 32'(is_rsp_to_get), 1);
    check_eq("t1_req_ready", 32'(req_in_ready), 0);
    rsp_in_valid = 0;
    tick();
    proc_done = 1; tick();
    proc_done = 0; tick();
    check_eq("t1_req_get", 32'(is_req_to_get), 1);
    settle();

    // 2: reset walk over all sets while queues are pending
    rsp_in_valid = 1; req_in_valid = 1; proc_done = 1; rst_start = 1;
    tick();
    rst_start = 0;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (is_rst_to_resume) begin
        check_eq("t2_set", 32'(rst_flush_stalled_set), 32'(k));
        k++;
      end
    end
    check_eq("t2_count", 32'(k), 16);
    check_eq("t2_rst_stall", 32'(rst_stall), 0);
    check_eq("t2_set_end", 32'(rst_flush_stalled_set), 0);
    settle();

    // 3: starvation promotes req after LIMIT losses, then counting restarts
    rsp_in_valid = 1; req_in_valid = 1; proc_done = 1;
    n = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (is_rsp_to_get) n++;
      if (is_req_to_get) begin intervals.push_back(n); n = 0; end
    end
    req_seen = intervals.size();
    check_eq("t3_req_grants", 32'(req_seen >= 2), 1);
    if (req_seen >= 2) begin
      check_eq("t3_first_wait", 32'(intervals[0]), 8);
      check_eq("t3_second_wait", 32'(intervals[1]), 8);
    end
    settle();

    // 4: stall set/clear collision, then stall blocks req traffic only
    req_stall_set = 1; clr_req_stall = 1;
    tick();
    check_eq("t4_clear_wins", 32'(req_stall), 0);
    clr_req_stall = 0;
    tick();
    check_eq("t4_stall_set", 32'(req_stall), 1);
    req_stall_set = 0;
    rsp_in_valid = 1; req_in_valid = 1; dma_req_in_valid = 1; proc_done = 1;
    n = 0; nf = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (is_req_to_get || is_dma_req_to_get) nf++;
      if (is_rsp_to_get) n++;
    end
    check_eq("t4_req_blocked", 32'(nf), 0);
    check_eq("t4_rsp_served", 32'(n > 0), 1);
    clear_inputs(); clr_req_stall = 1; tick();
    settle();

    // 5: asynchronous reset while a transaction is in flight
    rsp_in_valid = 1;
    tick(); tick();
    check_eq("t5_busy_before", 32'(busy), 1);
    #2 rst = 1;
    #1;
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_strobes", {25'd0, is_rst_to_resume, is_flush_to_resume, is_rsp_to_get,
             is_dma_read_to_resume, is_dma_write_to_resume, is_req_to_get, is_dma_req_to_get}, 0);
    check_eq("t5_ready_rdset", {29'd0, rsp_in_ready, rd_set_en, req_in_ready}, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    tick();
    check_eq("t5_rsp_after", 32'(is_rsp_to_get), 1);
    settle();

    // 6: simultaneous reset and flush starts share one walk
    rst_start = 1; flush_start = 1;
    tick();
    check_eq("t6_both_set", {30'd0, rst_stall, flush_stall}, 3);
    rst_start = 0; flush_start = 0; proc_done = 1;
    n = 0; nf = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (is_rst_to_resume || is_flush_to_resume) n++;
      if (is_flush_to_resume) nf++;
    end
    check_eq("t6_walk_count", 32'(n), 16);
    check_eq("t6_flush_grants", 32'(nf), 0);
    check_eq("t6_flags_clear", {30'd0, rst_stall, flush_stall}, 0);
    settle();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rsp_in_valid     = ($urandom_range(0, 2) == 0);
      req_in_valid     = ($urandom_range(0, 1) == 0);
      dma_req_in_valid = ($urandom_range(0, 2) == 0);
      dma_read_pend    = ($urandom_range(0, 5) == 0);
      dma_write_pend   = ($urandom_range(0, 5) == 0);
      rst_start        = ($urandom_range(0, 199) == 0);
      flush_start      = ($urandom_range(0, 149) == 0);
      req_stall_set    = ($urandom_range(0, 9) == 0);
      clr_req_stall    = ($urandom_range(0, 5) == 0);
      proc_done        = ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
